complete_arbiter: RTL and testbench
===================================

# complete_arbiter

Completion-side transmitter for the CDB. Collects finished physical-register tags from the functional units, buffers them per unit, and issues up to `N_WAY` tags per cycle onto `complete_dest_tag`. That bus is the one the CDB latch consumes and broadcasts to the ROB, the map table and the reservation stations. Tag value 0 means "no broadcast" on every lane, as it does throughout the CDB path.

## Interface

Parameters:
- `N_WAY`, default 2: number of CDB lanes driven per cycle.
- `N_FU`, default 4: number of functional-unit completion ports.
- `CDB_BITS`, default 6: physical-register tag width.
- `BUF_DEPTH`, default 2: per-FU completion FIFO depth; must be ≥1.

Ports:
- `clock` in, 1: the single clock; all state is updated on its rising edge.
- `reset` in, 1: asynchronous, active-low. 0 clears all state immediately.
- `squash` in, 1: synchronous flush of all buffered completions (branch mispredict).
- `fu_valid` in, `N_FU`: FU i presents a completed tag.
- `fu_tag` in, `N_FU`×`CDB_BITS`: completed destination tag per FU.
- `fu_ready` out, `N_FU`: FU i may complete this cycle.
- `complete_dest_tag` out, `N_WAY`×`CDB_BITS`: registered CDB lanes; 0 means the lane is idle.
- `bcast_count` out, 16: debug count of non-zero tags issued. Wraps modulo 2^16.

## Operation

- **Per-FU FIFO.**
  - Each FU has a FIFO of `BUF_DEPTH` entries with a count of width `$clog2(BUF_DEPTH)+1`.
  - `fu_ready[i]` is 1 when count < `BUF_DEPTH` and `reset`=1; otherwise 0.
  - `fu_ready[i]` depends on the registered count only. There is no pass-through credit for a same-cycle dequeue, so a full FIFO shows ready=0 even while it is dequeuing.
- **Enqueue.**
  - A tag is accepted when `fu_valid[i]` && `fu_ready[i]` && `fu_tag[i]` != 0.
  - A tag of 0 is dropped silently.
  - `fu_valid` while `fu_ready`=0 is dropped; avoiding this is the FU's responsibility. The bench checks it never happens.
- **Arbitration (combinational, each cycle).**
  - Scan FUs starting at `rr_ptr`, wrapping modulo `N_FU`.
  - Grant at most one head entry per non-empty FIFO, up to `N_WAY` grants total.
  - Grant k (in scan order) goes to lane k. Lanes with no grant are 0.
- **Pointer update.**
  - If any FIFO was granted, `rr_ptr` becomes (index of last granted FU + 1) mod `N_FU`.
  - If none was granted, `rr_ptr` holds.
- **Dequeue.** Granted FIFOs pop their head at the edge. The FIFO read and write pointers wrap modulo `BUF_DEPTH`.
- **Output register.**
  - `complete_dest_tag` captures the lane assignment at the edge.
  - `bcast_count` adds the number of non-zero lanes captured.
- **Squash.**
  - At the next edge: all FIFO counts and pointers go to 0, `complete_dest_tag` goes to all-zero, and `rr_ptr` goes to 0.
  - Enqueues and grants in the squash cycle are discarded.
  - `bcast_count` is not incremented for that cycle and is not cleared.
- **Reset** (`reset`=0, at any time, including mid-transfer):
  - FIFOs empty, `rr_ptr`=0.
  - `complete_dest_tag` all 0, `bcast_count`=0, `fu_ready` all 0.
  - After release, `fu_ready` is all 1 immediately, since the counts are 0.

## Timing

- **Minimum latency.** A tag accepted at edge t sits at a FIFO head during cycle t+1, is granted in cycle t+1, and is visible on `complete_dest_tag` during cycle t+2. That is 2 edges from acceptance to broadcast.
- **Duration.** Each broadcast tag is held for exactly one cycle. Next cycle the lane carries a different tag or 0, with no repeat unless the FU completes the same tag again.
- **Throughput.**
  - Sustained per-FU rate is 1 tag/cycle when `BUF_DEPTH` ≥2 and the FU wins the grant every cycle.
  - With `BUF_DEPTH`=1 it is 1 tag per 2 cycles, because there is no pass-through credit.
- **Simultaneous enqueue and dequeue** on the same FIFO in one cycle: the count is unchanged and both take effect.
- **Empty FIFOs:** if every FIFO is empty, all lanes are 0 the next cycle.
- **Fairness:** any non-empty FIFO is granted within ⌈`N_FU`/`N_WAY`⌉ cycles.

## Test plan

1. **Reset.** Assert `reset`=0 mid-run with FIFOs holding tags; release. Required: all lanes 0, `bcast_count`=0, `fu_ready`=4'b1111, and no stale tag ever appears.
2. **Single completion.** FU2 sends tag 5 at edge t. Required: `complete_dest_tag[0]`=5 and `[1]`=0 during cycle t+2 only; `bcast_count`=1.
3. **Round-robin.** All four FUs send tags 1,2,3,4 in the same cycle, `N_WAY`=2. Required: lanes {1,2} next cycle, then {3,4}; `rr_ptr` returns to 0.
4. **Backpressure.** FU0 sends tags 7,8 back-to-back while FUs 1-3 keep winning ahead of it. Required: `fu_ready[0]`=0 once 2 entries are held; the third tag is accepted only after a pop; output order is 7 then 8.
5. **Squash.** Queue 6 tags, then pulse `squash` for one cycle. Required: the next cycle all lanes are 0 and all `fu_ready`=1; the tags never appear; `bcast_count` is unchanged.
6. **Tag 0.** `fu_valid`=1 with `fu_tag`=0 on every FU. Required: nothing is enqueued, lanes stay 0, and `bcast_count` does not move.

Source files
------------

// File: rtl/complete_arbiter.sv
// Completion-side CDB transmitter: per-FU completion FIFOs feeding a round-robin
// arbiter that issues up to N_WAY tags per cycle onto registered CDB lanes.
module complete_arbiter #(
    parameter int unsigned N_WAY     = 2,
    parameter int unsigned N_FU      = 4,
    parameter int unsigned CDB_BITS  = 6,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      squash,
    input  logic [N_FU-1:0]           fu_valid,
    input  logic [N_FU*CDB_BITS-1:0]  fu_tag,
    output logic [N_FU-1:0]           fu_ready,
    output logic [N_WAY*CDB_BITS-1:0] complete_dest_tag,
    output logic [15:0]               bcast_count
);

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned RW = (N_FU > 1) ? $clog2(N_FU) : 1;

    logic [CW-1:0]             r_count [N_FU];
    logic [PW-1:0]             r_wptr  [N_FU];
    logic [PW-1:0]             r_rptr  [N_FU];
    logic [CDB_BITS-1:0]       r_mem   [N_FU][BUF_DEPTH];
    logic [RW-1:0]             r_rr_ptr;
    logic [N_WAY*CDB_BITS-1:0] r_dest;
    logic [15:0]               r_bcast;

    logic [N_FU-1:0]           w_push;
    logic [N_FU-1:0]           w_pop;
    logic [N_WAY*CDB_BITS-1:0] w_lanes;
    logic [RW-1:0]             w_rr_next;
    logic [15:0]               w_lane_cnt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(BUF_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Ready looks only at the registered count: a full FIFO stays not-ready while popping.
    always_comb begin
        fu_ready = '0;
        w_push   = '0;
        for (int unsigned f = 0; f < N_FU; f++) begin
            fu_ready[f] = reset && (r_count[f] < CW'(BUF_DEPTH));
            w_push[f]   = fu_valid[f] && fu_ready[f] && (fu_tag[f*CDB_BITS +: CDB_BITS] != '0);
        end
    end

    always_comb begin
        int unsigned n_grant;
        int unsigned idx_full;
        n_grant    = 0;
        idx_full   = 0;
        w_pop      = '0;
        w_lanes    = '0;
        w_rr_next  = r_rr_ptr;
        w_lane_cnt = '0;
        for (int unsigned j = 0; j < N_FU; j++) begin
            idx_full = 32'(r_rr_ptr) + j;
            if (idx_full >= N_FU) begin
                idx_full = idx_full - N_FU;
            end
            for (int unsigned f = 0; f < N_FU; f++) begin
                if (f == idx_full && r_count[f] != '0 && n_grant < N_WAY) begin
                    w_pop[f] = 1'b1;
                    for (int unsigned k = 0; k < N_WAY; k++) begin
                        if (k == n_grant) begin
                            w_lanes[k*CDB_BITS +: CDB_BITS] = r_mem[f][r_rptr[f]];
                        end
                    end
                    n_grant   = n_grant + 1;
                    w_rr_next = (f == N_FU - 1) ? '0 : RW'(f + 1);
                end
            end
        end
        for (int unsigned k = 0; k < N_WAY; k++) begin
            if (w_lanes[k*CDB_BITS +: CDB_BITS] != '0) begin
                w_lane_cnt = w_lane_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned f = 0; f < N_FU; f++) begin
            if (w_push[f] && !squash) begin
                r_mem[f][r_wptr[f]] <= fu_tag[f*CDB_BITS +: CDB_BITS];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned f = 0; f < N_FU; f++) begin
                r_count[f] <= '0;
                r_wptr[f]  <= '0;
                r_rptr[f]  <= '0;
            end
            r_rr_ptr <= '0;
            r_dest   <= '0;
            r_bcast  <= '0;
        end else if (squash) begin
            // Flush discards this cycle's enqueues and grants; the debug counter survives.
            for (int unsigned f = 0; f < N_FU; f++) begin
                r_count[f] <= '0;
                r_wptr[f]  <= '0;
                r_rptr[f]  <= '0;
            end
            r_rr_ptr <= '0;
            r_dest   <= '0;
        end else begin
            for (int unsigned f = 0; f < N_FU; f++) begin
                if (w_push[f]) begin
                    r_wptr[f] <= ptr_inc(r_wptr[f]);
                end
                if (w_pop[f]) begin
                    r_rptr[f] <= ptr_inc(r_rptr[f]);
                end
                case ({w_push[f], w_pop[f]})
                    2'b10:   r_count[f] <= r_count[f] + 1'b1;
                    2'b01:   r_count[f] <= r_count[f] - 1'b1;
                    default: r_count[f] <= r_count[f];
                endcase
            end
            r_rr_ptr <= w_rr_next;
            r_dest   <= w_lanes;
            r_bcast  <= r_bcast + w_lane_cnt;
        end
    end

    assign complete_dest_tag = r_dest;
    assign bcast_count       = r_bcast;

endmodule

// File: tb/tb_complete_arbiter.sv
// Directed self-checking bench for complete_arbiter (default parameters: 2 lanes, 4 FUs,
// 6-bit tags, depth-2 FIFOs).
module tb_complete_arbiter;

    logic        clock;
    logic        reset;
    logic        squash;
    logic [3:0]  fu_valid;
    logic [23:0] fu_tag;
    logic [3:0]  fu_ready;
    logic [11:0] complete_dest_tag;
    logic [15:0] bcast_count;

    int n_cmp = 0;
    int n_err = 0;

    complete_arbiter #(
        .N_WAY(2),
        .N_FU(4),
        .CDB_BITS(6),
        .BUF_DEPTH(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .squash(squash),
        .fu_valid(fu_valid),
        .fu_tag(fu_tag),
        .fu_ready(fu_ready),
        .complete_dest_tag(complete_dest_tag),
        .bcast_count(bcast_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Protocol monitor: the bench must never present a completion to a not-ready FU.
    always @(posedge clock) begin
        if (reset) begin
            n_cmp++;
            if ((fu_valid & ~fu_ready) !== 4'b0000) begin
                n_err++;
                $display("FAIL valid_while_not_ready: got %b want 0000", fu_valid & ~fu_ready);
            end
        end
    end

    function automatic logic [11:0] lanes(input int a, input int b);
        return {6'(b), 6'(a)};
    endfunction

    function automatic logic [23:0] tags(input int t0, input int t1, input int t2, input int t3);
        return {6'(t3), 6'(t2), 6'(t1), 6'(t0)};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [23:0] t);
        fu_valid = v;
        fu_tag   = t;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_cmp++;
        if (complete_dest_tag !== lanes(0, 0)) begin
            n_err++;
            $display("FAIL por_lanes: got %h want %h", complete_dest_tag, lanes(0, 0));
        end
        n_cmp++;
        if (bcast_count !== 16'd0) begin
            n_err++;
            $display("FAIL por_bcast: got %0d want 0", bcast_count);
        end
        n_cmp++;
        if (fu_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL por_ready: got %b want 0000", fu_ready);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (fu_ready !== 4'b1111) begin
            n_err++;
            $display("FAIL release_ready: got %b want 1111", fu_ready);
        end
        drive(4'b1111, tags(41, 42, 43, 44));
        tick();
        drive(4'b0000, '0);
        tick();
        n_cmp++;
        if (complete_dest_tag !== lanes(41, 42)) begin
            n_err++;
            $display("FAIL prereset_lanes: got %h want %h", complete_dest_tag, lanes(41, 42));
        end
        // FU2/FU3 still hold 43 and 44 here; reset must wipe them.
        reset = 1'b0;
        #1;
        n_cmp++;
        if (complete_dest_tag !== lanes(0, 0) || bcast_count !== 16'd0 || fu_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL midreset_state: got lanes=%h bcast=%0d ready=%b want lanes=000 bcast=0 ready=0000",
                     complete_dest_tag, bcast_count, fu_ready);
        end
        tick();
        tick();
        reset = 1'b1;
        #1;
        n_cmp++;
        if (fu_ready !== 4'b1111) begin
            n_err++;
            $display("FAIL midreset_release_ready: got %b want 1111", fu_ready);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (complete_dest_tag !== lanes(0, 0) || bcast_count !== 16'd0) begin
                n_err++;
                $display("FAIL reset_no_stale[%0d]: got lanes=%h bcast=%0d want lanes=000 bcast=0",
                         c, complete_dest_tag, bcast_count);
            end
        end
    endtask

    task automatic test_single();
        drive(4'b0100, tags(0, 0, 5, 0));
        tick();
        drive(4'b0000, '0);
        n_cmp++;
        if (complete_dest_tag !== lanes(0, 0)) begin
            n_err++;
            $display("FAIL single_t1: got %h want %h", complete_dest_tag, lanes(0, 0));
        end
        tick();
        n_cmp++;
        if (complete_dest_tag !== lanes(5, 0) || bcast_count !== 16'd1) begin
            n_err++;
            $display("FAIL single_t2: got lanes=%h bcast=%0d want lanes=%h bcast=1",
                     complete_dest_tag, bcast_count, lanes(5, 0));
        end
        tick();
        n_cmp++;
        if (complete_dest_tag !== lanes(0, 0) || bcast_count !== 16'd1) begin
            n_err++;
            $display("FAIL single_t3: got lanes=%h bcast=%0d want lanes=000 bcast=1",
                     complete_dest_tag, bcast_count);
        end
    endtask

    task automatic test_round_robin();
        squash = 1'b1;  // rr_ptr back to 0 (it is 3 after the single completion)
        tick();
        squash = 1'b0;
        drive(4'b1111, tags(1, 2, 3, 4));
        tick();
        drive(4'b0000, '0);
        tick();
        n_cmp++;
        if (complete_dest_tag !== lanes(1, 2)) begin
            n_err++;
            $display("FAIL rr_first: got %h want %h", complete_dest_tag, lanes(1, 2));
        end
        tick();
        n_cmp++;
        if (complete_dest_tag !== lanes(3, 4)) begin
            n_err++;
            $display("FAIL rr_second: got %h want %h", complete_dest_tag, lanes(3, 4));
        end
        // With rr_ptr at 0, FU1 must take lane 0 ahead of FU3.
        drive(4'b1010, tags(0, 6, 0, 7));
        tick();
        drive(4'b0000, '0);
        n_cmp++;
        if (complete_dest_tag !== lanes(0, 0) || bcast_count !== 16'd5) begin
            n_err++;
            $display("FAIL rr_drain: got lanes=%h bcast=%0d want lanes=000 bcast=5",
                     complete_dest_tag, bcast_count);
        end
        tick();
        n_cmp++;
        if (complete_dest_tag !== lanes(6, 7) || bcast_count !== 16'd7) begin
            n_err++;
            $display("FAIL rr_ptr_zero: got lanes=%h bcast=%0d want lanes=%h bcast=7",
                     complete_dest_tag, bcast_count, lanes(6, 7));
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [11:0] exp_lanes [6];
        logic [3:0]  exp_rdy0;
        exp_lanes[0] = lanes(30, 0);
        exp_lanes[1] = lanes(11, 12);
        exp_lanes[2] = lanes(13, 7);
        exp_lanes[3] = lanes(14, 15);
        exp_lanes[4] = lanes(16, 8);
        exp_lanes[5] = lanes(9, 0);
        exp_rdy0     = 4'b1010;  // index 0..3 -> bit; FU0 full after 2nd and 4th step
        drive(4'b0001, tags(30, 0, 0, 0));  // moves rr_ptr to 1
        tick();
        drive(4'b1111, tags(7, 11, 12, 13));
        tick();
        for (int s = 0; s < 6; s++) begin
            case (s)
                0:       drive(4'b1111, tags(8, 14, 15, 16));
                2:       drive(4'b0001, tags(9, 0, 0, 0));
                default: drive(4'b0000, '0);
            endcase
            n_cmp++;
            if (complete_dest_tag !== exp_lanes[s]) begin
                n_err++;
                $display("FAIL bp_lanes[%0d]: got %h want %h", s, complete_dest_tag, exp_lanes[s]);
            end
            if (s < 4) begin
                n_cmp++;
                if (fu_ready[0] !== ~exp_rdy0[s]) begin
                    n_err++;
                    $display("FAIL bp_ready0[%0d]: got %b want %b", s, fu_ready[0], ~exp_rdy0[s]);
                end
            end
            tick();
        end
        n_cmp++;
        if (complete_dest_tag !== lanes(0, 0) || bcast_count !== 16'd17) begin
            n_err++;
            $display("FAIL bp_end: got lanes=%h bcast=%0d want lanes=000 bcast=17",
                     complete_dest_tag, bcast_count);
        end
    endtask

    task automatic test_squash();
        drive(4'b1111, tags(21, 22, 23, 24));
        tick();
        drive(4'b1111, tags(27, 25, 26, 28));
        tick();
        n_cmp++;
        if (complete_dest_tag !== lanes(22, 23) || bcast_count !== 16'd19) begin
            n_err++;
            $display("FAIL sq_before: got lanes=%h bcast=%0d want lanes=%h bcast=19",
                     complete_dest_tag, bcast_count, lanes(22, 23));
        end
        // Six tags buffered; an enqueue of 29 in the squash cycle must also vanish.
        squash = 1'b1;
        drive(4'b0010, tags(0, 29, 0, 0));
        tick();
        squash = 1'b0;
        drive(4'b0000, '0);
        n_cmp++;
        if (complete_dest_tag !== lanes(0, 0) || fu_ready !== 4'b1111 || bcast_count !== 16'd19) begin
            n_err++;
            $display("FAIL sq_after: got lanes=%h ready=%b bcast=%0d want lanes=000 ready=1111 bcast=19",
                     complete_dest_tag, fu_ready, bcast_count);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++;
            if (complete_dest_tag !== lanes(0, 0) || bcast_count !== 16'd19) begin
                n_err++;
                $display("FAIL sq_never[%0d]: got lanes=%h bcast=%0d want lanes=000 bcast=19",
                         c, complete_dest_tag, bcast_count);
            end
        end
    endtask

    task automatic test_tag_zero();
        drive(4'b1111, tags(0, 0, 0, 0));
        for (int c = 0; c < 4; c++) begin
            if (c == 2) begin
                drive(4'b0000, '0);
            end
            tick();
            n_cmp++;
            if (complete_dest_tag !== lanes(0, 0) || fu_ready !== 4'b1111 || bcast_count !== 16'd19) begin
                n_err++;
                $display("FAIL tag0[%0d]: got lanes=%h ready=%b bcast=%0d want lanes=000 ready=1111 bcast=19",
                         c, complete_dest_tag, fu_ready, bcast_count);
            end
        end
    endtask

    initial begin
        reset    = 1'b0;
        squash   = 1'b0;
        fu_valid = '0;
        fu_tag   = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_squash();
        test_tag_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
